// File: rtl/align_seq_if.sv
// align_seq_if: valid/ready handshake bundle for the align_seq normaliser.
// slave is the normaliser side, master is the producer/consumer side.
interface align_seq_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = $clog2(W) + 1
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_zero;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count, out_zero
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_zero
  );
endinterface

// File: rtl/align_seq.sv
// align_seq: multi-cycle leading-zero normaliser. Each BUSY cycle inspects
// the top 2^ORDER bits of the working word and shifts them out (all zero)
// or aligns the first one to the MSB. Optional macro ALIGN_SEQ_EARLY_EN
// ends the operation on the step that finds the leading one; otherwise a
// fixed W/HW steps are always run and later steps are no-ops.
module align_seq #(
  parameter int unsigned ORDER = 3,
  parameter int unsigned W     = 32
) (
  input  logic      clock,
  input  logic      reset,
  align_seq_if.slave bus
);
  localparam int unsigned HW    = 1 << ORDER;
  localparam int unsigned NSTEP = W / HW;
  localparam int unsigned CW    = $clog2(W) + 1;
  localparam int unsigned SW    = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    work_q, work_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   steps_q, steps_d;
  logic            found_q, found_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            zero_q, zero_d;
  logic [HW-1:0]   top;
  logic [ORDER-1:0] lz;
  logic            in_ready_c;
  logic            accept;
  logic            last_step;

  // Leading zeros of a nonzero HW-bit slice; the highest set bit wins.
  function automatic logic [ORDER-1:0] clz_top(input logic [HW-1:0] t);
    logic [ORDER-1:0] r;
    r = '0;
    for (int i = 0; i < int'(HW); i++) begin
      if (t[i]) r = ORDER'(int'(HW) - 1 - i);
    end
    return r;
  endfunction

  // Ready whenever idle, or when the held result is being taken this cycle.
  assign in_ready_c   = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept       = bus.in_valid & in_ready_c;
  assign bus.in_ready = in_ready_c;

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_count = cnt_q;
  assign bus.out_zero  = zero_q;

  // Next-state, align step and result capture.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    count_d   = count_q;
    steps_d   = steps_q;
    found_d   = found_q;
    valid_d   = valid_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    last_step = 1'b0;
    top       = work_q[W-1 -: HW];
    lz        = clz_top(top);

    case (state_q)
      IDLE: begin
      end
      BUSY: begin
        steps_d = steps_q + SW'(1);
        if (!found_q) begin
          if (top == '0) begin
            work_d  = work_q << HW;
            count_d = count_q + CW'(HW);
          end else begin
            work_d  = work_q << lz;
            count_d = count_q + CW'(lz);
            found_d = 1'b1;
          end
        end
        last_step = (steps_d == SW'(NSTEP));
`ifdef ALIGN_SEQ_EARLY_EN
        last_step = last_step | (found_d & ~found_q);
`endif
        if (last_step) begin
          valid_d = 1'b1;
          data_d  = work_d;
          cnt_d   = count_d;
          zero_d  = (count_d == CW'(W));
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new word may be loaded from IDLE or during the DONE handoff.
    if (accept) begin
      work_d  = bus.in_data;
      count_d = '0;
      steps_d = '0;
      found_d = 1'b0;
      state_d = BUSY;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
      steps_q <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      steps_q <= steps_d;
      found_q <= found_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_align_seq.sv
// tb_align_seq: directed plus randomized checks of align_seq (ORDER=3, W=32)
// against a transaction-level reference of clz/shift and step latency.
module tb_align_seq;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   seen_rst = 1'b0;

  align_seq_if #(.W(W)) bus ();

  align_seq #(.ORDER(3), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) seen_rst <= 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int ref_clz(input logic [31:0] d);
    int n;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int ref_steps(input int clz);
`ifdef ALIGN_SEQ_EARLY_EN
    int n;
    n = clz / 8 + 1;
    if (n > 4) n = 4;
    return n;
`else
    return (clz >= 0) ? 4 : 4;
`endif
  endfunction

  // Reference: one pending transaction, result due N edges after accept.
  bit          m_have  = 1'b0;
  bit          m_clean = 1'b1;
  int          m_acc   = 0;
  int          m_n     = 0;
  logic [31:0] m_data  = '0;
  int          m_cnt   = 0;
  bit          exp_valid, exp_ready;

  always @(negedge clock) begin
    exp_valid = m_have && (cyc >= m_acc + m_n);
    exp_ready = !m_have || (exp_valid && bus.out_ready);
    if (seen_rst) begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      if (exp_valid) begin
        m_clean = 1'b0;
        chk("out_data", bus.out_data, m_data);
        chk("out_count", 32'(bus.out_count), 32'(m_cnt));
        chk("out_zero", 32'(bus.out_zero), 32'(m_cnt == 32));
      end else if (m_clean) begin
        chk("idle_data", bus.out_data, 32'h0);
        chk("idle_count", 32'(bus.out_count), 32'h0);
        chk("idle_zero", 32'(bus.out_zero), 32'h0);
      end
    end
    if (reset) begin
      m_have  = 1'b0;
      m_clean = 1'b1;
    end else if (seen_rst) begin
      if (exp_valid && bus.out_ready) m_have = 1'b0;
      if (exp_ready && bus.in_valid) begin
        m_have = 1'b1;
        m_acc  = cyc + 1;
        m_cnt  = ref_clz(bus.in_data);
        m_n    = ref_steps(m_cnt);
        m_data = (m_cnt == 32) ? 32'h0 : (bus.in_data << m_cnt);
      end
    end
  end

  // Waits (bounded) for in_ready; returns the edge on which acceptance occurs.
  task automatic wait_accept(output int k);
    bit ok;
    ok = 1'b0;
    k  = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        k  = cyc + 1;
      end
    end
    if (!ok) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_valid(input int k, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        ok  = 1'b1;
        lat = cyc - k;
      end
    end
    if (!ok) chk("valid_timeout", 32'h0, 32'h1);
  endtask

  task automatic run_one(input string nm, input logic [31:0] d, input logic [31:0] ed,
                         input int ec, input int el);
    int k, lat;
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    wait_accept(k);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    wait_valid(k, lat);
    chk({nm, "_data"}, bus.out_data, ed);
    chk({nm, "_count"}, 32'(bus.out_count), 32'(ec));
    chk({nm, "_zero"}, 32'(bus.out_zero), 32'(ec == 32));
    chk({nm, "_lat"}, 32'(lat), 32'(el));
  endtask

  int early2, early1;

  initial begin
    int k, k_prev, lat, prev_n;
    logic [31:0] d;
`ifdef ALIGN_SEQ_EARLY_EN
    early1 = 1;
    early2 = 2;
`else
    early1 = 4;
    early2 = 4;
`endif
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    fork
      begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);

    run_one("msb", 32'h8000_0000, 32'h8000_0000, 0, early1);
    run_one("b16", 32'h0001_0000, 32'h8000_0000, 15, early2);
    run_one("zero", 32'h0000_0000, 32'h0000_0000, 32, 4);

    // Backpressure: hold a result, then hand off back-to-back.
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00F0_0000;
    wait_accept(k);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    wait_valid(k, lat);
    chk("bp_data", bus.out_data, 32'hF000_0000);
    chk("bp_count", 32'(bus.out_count), 32'd8);
    repeat (5) begin
      @(negedge clock);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_hold_data", bus.out_data, 32'hF000_0000);
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_0001;
    @(negedge clock);
    chk("b2b_in_ready", 32'(bus.in_ready), 32'h1);
    k = cyc + 1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    wait_valid(k, lat);
    chk("b2b_data", bus.out_data, 32'h8000_0000);
    chk("b2b_count", 32'(bus.out_count), 32'd31);
    chk("b2b_lat", 32'(lat), 32'd4);

    // Reset in the middle of an operation.
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0;
    wait_accept(k);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_valid", 32'(bus.out_valid), 32'h0);
    chk("abort_data", bus.out_data, 32'h0);
    chk("abort_count", 32'(bus.out_count), 32'h0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'h1);
    repeat (8) @(negedge clock);
    chk("abort_no_stale", 32'(bus.out_valid), 32'h0);

    // Streaming: in_valid held, out_ready high, one result per N+1 cycles.
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    k_prev = 0;
    prev_n = 0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom >> $urandom_range(0, 32);
      bus.in_data = d;
      wait_accept(k);
      if (i > 0) chk("stream_gap", 32'(k - k_prev), 32'(prev_n + 1));
      k_prev = k;
      prev_n = ref_steps(ref_clz(d));
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;

    // Random handshake traffic on both sides.
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.in_data   = $urandom >> $urandom_range(0, 32);
      @(posedge clock); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
